// File: rtl/div_pkg.sv
// div_pkg: shared op encodings, FSM states, cache tag and result select for the divider issue controller
package div_pkg;
    localparam int DIV_LAT = 67;

    typedef enum logic [2:0] {
        OP_DIV   = 3'd0,
        OP_DIVU  = 3'd1,
        OP_REM   = 3'd2,
        OP_REMU  = 3'd3,
        OP_DIVW  = 3'd4,
        OP_DIVUW = 3'd5,
        OP_REMW  = 3'd6,
        OP_REMUW = 3'd7
    } div_op_e;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        sign;
        logic        w32;
    } div_tag_t;

    // Pick quotient or remainder out of {rem, quot}; W forms sign-extend the low word.
    function automatic logic [63:0] sel_result(input logic [2:0] op, input logic [127:0] res);
        logic [63:0] sel;
        sel = op[1] ? res[127:64] : res[63:0];
        return op[2] ? {{32{sel[31]}}, sel[31:0]} : sel;
    endfunction
endpackage

// File: rtl/div_reuse_buf.sv
// div_reuse_buf: one-entry cache of the last completed divide, keyed on operands, sign and width
module div_reuse_buf
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [63:0]  wr_rs1,
    input  logic [63:0]  wr_rs2,
    input  logic         wr_sign,
    input  logic         wr_32,
    input  logic [127:0] wr_data,
    input  logic [63:0]  lk_rs1,
    input  logic [63:0]  lk_rs2,
    input  logic         lk_sign,
    input  logic         lk_32,
    output logic         hit,
    output logic [127:0] rd_data
);
    logic         vld_q, vld_d;
    div_tag_t     tag_q, tag_d;
    logic [127:0] data_q, data_d;

    // Overwrite the single entry on every completed divide; report a tag match for lookup.
    always_comb begin
        vld_d   = vld_q | wr_en;
        tag_d   = wr_en ? {wr_rs1, wr_rs2, wr_sign, wr_32} : tag_q;
        data_d  = wr_en ? wr_data : data_q;
        hit     = vld_q && (tag_q == {lk_rs1, lk_rs2, lk_sign, lk_32});
        rd_data = data_q;
    end

    // Entry storage; invalid after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/writeback control for the multi-cycle divider; DIV_RESULT_REUSE_EN adds a one-entry result cache
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            op_valid,
    input  logic [2:0]      div_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            div_valid,
    output logic            div_sign,
    output logic            div_32,
    output logic [XLEN-1:0] div_rs1,
    output logic [XLEN-1:0] div_rs2,
    input  logic            div_ready,
    input  logic [127:0]    div_result
);
    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            sign_q, sign_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
    logic            hit;
    logic [127:0]    hit_data;

`ifdef DIV_RESULT_REUSE_EN
    logic cache_wr;
    assign cache_wr = (state_q == S_BUSY) && div_ready && !flush;
    div_reuse_buf u_reuse (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cache_wr),
        .wr_rs1  (rs1_q),
        .wr_rs2  (rs2_q),
        .wr_sign (sign_q),
        .wr_32   (op_q[2]),
        .wr_data (div_result),
        .lk_rs1  (rs1_data),
        .lk_rs2  (rs2_data),
        .lk_sign (~div_op[0]),
        .lk_32   (div_op[2]),
        .hit     (hit),
        .rd_data (hit_data)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    assign result   = result_q;
    assign div_sign = sign_q;
    assign div_32   = op_q[2];
    assign div_rs1  = rs1_q;
    assign div_rs2  = rs2_q;

    // Next state, operand capture, result select and handshake outputs.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sign_d       = sign_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        result_d     = result_q;
        stall        = 1'b0;
        div_valid    = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    stall    = 1'b1;
                    op_d     = div_op;
                    sign_d   = ~div_op[0];
                    rs1_d    = rs1_data;
                    rs2_d    = rs2_data;
                    state_d  = hit ? S_DONE : S_BUSY;
                    result_d = hit ? sel_result(div_op, hit_data) : result_q;
                end
            end
            S_BUSY: begin
                stall     = 1'b1;
                div_valid = 1'b1;
                if (div_ready && !flush) begin
                    result_d = sel_result(op_q, div_result);
                    state_d  = S_DONE;
                end else if (flush) begin
                    state_d = div_ready ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                stall     = 1'b1;
                div_valid = 1'b1;
                state_d   = div_ready ? S_IDLE : S_DRAIN;
            end
            default: begin
                result_valid = ~flush;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State, held operands and registered writeback value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sign_q   <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed and random checks of div_issue_ctrl against an RV64M reference and a behavioural divider
module tb_div_issue_ctrl;
    import div_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         op_valid = 1'b0;
    logic [2:0]   div_op = '0;
    logic [63:0]  rs1_data = '0, rs2_data = '0;
    logic         stall, result_valid, div_valid, div_sign, div_32, div_ready;
    logic [63:0]  result, div_rs1, div_rs2;
    logic [127:0] div_result;

    int total = 0;
    int bad = 0;
    int cnt;
    logic [31:0] junk = 32'hdead_beef;
    logic        special;
    logic [63:0] dq, dr;

    logic        c_vld = 1'b0;
    logic [63:0] c_a, c_b;
    logic        c_sign, c_w;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .op_valid     (op_valid),
        .div_op       (div_op),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .div_valid    (div_valid),
        .div_sign     (div_sign),
        .div_32       (div_32),
        .div_rs1      (div_rs1),
        .div_rs2      (div_rs2),
        .div_ready    (div_ready),
        .div_result   (div_result)
    );

    function automatic logic [63:0] golden(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q, r;
        a32 = a[31:0];
        b32 = b[31:0];
        if (op[2]) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hffff_ffff) begin q32 = a32; r32 = 0; end
            else if (!op[0]) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            s32 = op[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (b == 0) begin q = '1; r = a; end
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; end
        else if (!op[0]) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        else begin q = a / b; r = a % b; end
        return op[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[2]) return b[31:0] == 0 || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hffff_ffff);
        return b == 0 || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Behavioural divider: early-out on zero divisor / overflow, otherwise ready on its 67th busy cycle.
    always_comb begin
        special    = is_special({div_32, 1'b0, ~div_sign}, div_rs1, div_rs2);
        div_ready  = div_valid && (special || cnt == DIV_LAT - 1);
        dq         = golden({div_32, 1'b0, ~div_sign}, div_rs1, div_rs2);
        dr         = golden({div_32, 1'b1, ~div_sign}, div_rs1, div_rs2);
        div_result = div_32 ? {junk, dr[31:0], ~junk, dq[31:0]} : {dr, dq};
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 0;
        else cnt <= div_valid ? cnt + 1 : 0;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic bit cache_hit(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_RESULT_REUSE_EN
        return c_vld && c_a == a && c_b == b && c_sign == ~op[0] && c_w == op[2];
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        int lat, exp_lat, stall_cyc, dv_cyc;
        bit hit, hold_ok;
        hit = cache_hit(op, a, b);
        exp_lat = hit ? 1 : is_special(op, a, b) ? 2 : DIV_LAT + 1;
        @(negedge clk);
        op_valid = 1'b1; div_op = op; rs1_data = a; rs2_data = b; junk = $urandom;
        #1;
        check({name, ".stall0"}, 64'(stall), 64'd1);
        lat = 0; stall_cyc = 1; dv_cyc = 0; hold_ok = 1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (div_valid) begin
                dv_cyc++;
                if (div_rs1 !== a || div_rs2 !== b || div_sign !== ~op[0] || div_32 !== op[2]) hold_ok = 0;
            end
            if (!result_valid && stall) stall_cyc++;
        end while (!result_valid && lat < 200);
        check({name, ".lat"}, 64'(lat), 64'(exp_lat));
        check({name, ".res"}, result, exp);
        check({name, ".stallcyc"}, 64'(stall_cyc), 64'(exp_lat));
        check({name, ".stalldone"}, 64'(stall), 64'd0);
        check({name, ".dvcyc"}, 64'(dv_cyc), 64'(hit ? 0 : exp_lat - 1));
        check({name, ".hold"}, 64'(hold_ok), 64'd1);
        c_vld = 1'b1; c_a = a; c_b = b; c_sign = ~op[0]; c_w = op[2];
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic flush_op(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            input int fcyc);
        int dv_cyc, stall_cyc, rv_cyc;
        @(negedge clk);
        op_valid = 1'b1; div_op = op; rs1_data = a; rs2_data = b;
        #1;
        stall_cyc = stall ? 1 : 0; dv_cyc = 0; rv_cyc = 0;
        for (int c = 1; c <= DIV_LAT + 6; c++) begin
            @(posedge clk); #1;
            flush = 1'b0;
            if (div_valid) dv_cyc++;
            if (stall) stall_cyc++;
            if (result_valid) rv_cyc++;
            if (c == fcyc) begin
                @(negedge clk);
                flush = 1'b1; op_valid = 1'b0;
            end
        end
        check({name, ".rv"}, 64'(rv_cyc), 64'd0);
        check({name, ".dvcyc"}, 64'(dv_cyc), 64'(is_special(op, a, b) ? 1 : DIV_LAT));
        check({name, ".stallcyc"}, 64'(stall_cyc), 64'(is_special(op, a, b) ? 2 : DIV_LAT + 1));
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(($urandom_range(0, 40)));
            4: return 64'h0000_0000_8000_0000;
            5: return 64'h0000_0000_ffff_ffff;
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        logic [63:0] ra, rb;
        logic [2:0]  rop;
        #1;
        check("rst.stall", 64'(stall), 0);
        check("rst.rv", 64'(result_valid), 0);
        check("rst.result", result, 0);
        check("rst.dv", 64'(div_valid), 0);
        check("rst.sign", 64'(div_sign), 0);
        check("rst.w32", 64'(div_32), 0);
        check("rst.rs1", div_rs1, 0);
        check("rst.rs2", div_rs2, 0);
        @(negedge clk);
        rst = 1'b1;

        run_op("div_m7_2", OP_DIV, -64'sd7, 64'd2, 64'hffff_ffff_ffff_fffd);
        run_op("rem_m7_2", OP_REM, -64'sd7, 64'd2, 64'hffff_ffff_ffff_ffff);
        run_op("divu_z", OP_DIVU, 64'h1234, 64'd0, 64'hffff_ffff_ffff_ffff);
        run_op("remu_z", OP_REMU, 64'h1234, 64'd0, 64'h1234);
        run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, '1, 64'd0);
        run_op("divw_ovf", OP_DIVW, 64'h0000_0001_8000_0000, '1, 64'hffff_ffff_8000_0000);
        run_op("remuw", OP_REMUW, 64'hffff_ffff_ffff_fff9, 64'd2, 64'd1);

        flush_op("fl_div", OP_DIV, 64'd100, 64'd7, 10);
        run_op("divu_after_fl", OP_DIVU, 64'd100, 64'd7, 64'd14);
        flush_op("fl_drain", OP_DIVU, 64'd1000, 64'd3, 20);
        run_op("divu_nocache", OP_DIVU, 64'd1000, 64'd3, 64'd333);
        flush_op("fl_ready", OP_DIVU, 64'd55, 64'd0, 1);
        run_op("reuse_div", OP_DIV, 64'd100, 64'd7, 64'd14);
        run_op("reuse_rem", OP_REM, 64'd100, 64'd7, 64'd2);

        @(negedge clk);
        op_valid = 1'b1; flush = 1'b1; div_op = OP_DIV; rs1_data = 64'd9; rs2_data = 64'd4;
        #1;
        check("idle_flush.stall", 64'(stall), 0);
        @(posedge clk); #1;
        check("idle_flush.dv", 64'(div_valid), 0);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;

        @(negedge clk);
        op_valid = 1'b1; div_op = OP_DIVU; rs1_data = 64'd77; rs2_data = 64'd5;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        #1;
        check("midrst.stall", 64'(stall), 0);
        check("midrst.dv", 64'(div_valid), 0);
        check("midrst.result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        c_vld = 1'b0;
        run_op("after_rst", OP_REMU, 64'd77, 64'd5, 64'd2);

        ra = 64'd0; rb = 64'd1;
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin ra = pick(); rb = pick(); end
            run_op($sformatf("rnd%0d", i), rop, ra, rb, golden(rop, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
